mac_seq_ctrl: RTL

- Parametrised cycle sequencer for the MAC datapath.
- After a start pulse it steps a shared weight/pixel select through N_TAPS taps. It drives a one-hot lane enable (within a group) and a one-hot group enable that track the current tap.
- It then waits a programmable drain, fires the ENX latch strobe, and raises Output_Valid.
- Adds stall, restart/overrun handling and a busy flag.

---
 rtl/mac_ctrl_pkg.sv | 36 +++
 rtl/mac_seq_ctrl_onehot_shift.sv | 39 +++
 rtl/mac_seq_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the MAC sequencing controller and its datapath:
// FSM state encoding, a constant-foldable clog2 and the default geometry.
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    FIRE  = 3'd3,
    VALID = 3'd4
  } state_e;

  localparam int DEF_N_TAPS    = 112;
  localparam int DEF_GRP_SIZE  = 8;
  localparam int DEF_N_GRP     = 14;
  localparam int DEF_DRAIN_CYC = 33;

  // Returns 0 for values 0 and 1, so that it folds cleanly at elaboration.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mac_seq_ctrl_onehot_shift.sv
// One-hot register: resets and loads to bit0, shifts left on request.
// Used for both the lane enable and the group enable of the MAC array.
module onehot_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  output logic [WIDTH-1:0] onehot_o
);

  localparam logic [WIDTH-1:0] BIT0 = WIDTH'(1);

  logic [WIDTH-1:0] onehot_q;
  logic [WIDTH-1:0] onehot_d;

  always_comb begin
    onehot_d = onehot_q;
    if (load_i) begin
      onehot_d = BIT0;
    end else if (shift_i) begin
      onehot_d = onehot_q << 1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_q <= BIT0;
    end else begin
      onehot_q <= onehot_d;
    end
  end

  assign onehot_o = onehot_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Cycle sequencer for the MAC datapath: walks N_TAPS weight/pixel taps,
// waits a drain period, strobes ENX and then flags Output_Valid.
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int N_TAPS     = DEF_N_TAPS,
  parameter int GRP_SIZE   = DEF_GRP_SIZE,
  parameter int N_GRP      = DEF_N_GRP,
  parameter int DRAIN_CYC  = DEF_DRAIN_CYC,
  parameter bit RESTART_EN = 1'b1,
  localparam int SEL_W     = cnt_width(N_TAPS)
) (
  input  logic                clk,
  input  logic                GlobalReset_n,
  input  logic                Input_Valid,
  input  logic                Stall,
  output logic [SEL_W-1:0]    WeightX_Select,
  output logic [SEL_W-1:0]    PixelX_Select,
  output logic [GRP_SIZE-1:0] ENX_Int,
  output logic [N_GRP-1:0]    ENX_Int_2,
  output logic                ENX,
  output logic                Output_Valid,
  output logic                Busy,
  output logic                Overrun
);

  localparam int DRN_W = cnt_width(DRAIN_CYC);

  localparam logic [SEL_W-1:0] LAST_TAP   = SEL_W'(N_TAPS - 1);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
  localparam state_e           RUN_EXIT   = (DRAIN_CYC == 0) ? FIRE : DRAIN;

  generate
    if (N_TAPS < 1 || N_TAPS > GRP_SIZE * N_GRP) begin : g_bad_taps
      $error("mac_seq_ctrl: N_TAPS must be in 1..GRP_SIZE*N_GRP");
    end
    if (DRAIN_CYC < 0) begin : g_bad_drain
      $error("mac_seq_ctrl: DRAIN_CYC must not be negative");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [SEL_W-1:0] tap_q, tap_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic             enx_q, valid_q, busy_q, overrun_q;
  logic             overrun_d;

  logic             start;
  logic             advance;
  logic             to_idle;
  logic             lane_wrap;

  logic             lane_load, lane_shift;
  logic             grp_load, grp_shift;

  // A start is honoured from IDLE and VALID always; elsewhere only when
  // restarts are enabled, in which case the running sequence is abandoned.
  assign start = Input_Valid &&
                 ((state_q == IDLE) || (state_q == VALID) || RESTART_EN);

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    drain_d   = drain_q;
    advance   = 1'b0;
    to_idle   = 1'b0;
    overrun_d = 1'b0;

    if (start) begin
      state_d = RUN;
      tap_d   = '0;
      drain_d = '0;
    end else begin
      // Only reachable with restarts disabled: the request is dropped.
      if (Input_Valid && (state_q inside {RUN, DRAIN, FIRE})) begin
        overrun_d = 1'b1;
      end

      unique case (state_q)
        IDLE: ;
        RUN: begin
          if (!Stall) begin
            if (tap_q == LAST_TAP) begin
              state_d = RUN_EXIT;
            end else begin
              tap_d   = tap_q + SEL_W'(1);
              advance = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_d = FIRE;
          end else begin
            drain_d = drain_q + DRN_W'(1);
          end
        end
        FIRE: state_d = VALID;
        VALID: begin
          state_d = IDLE;
          tap_d   = '0;
          to_idle = 1'b1;
        end
        default: begin
          state_d = IDLE;
          tap_d   = '0;
          to_idle = 1'b1;
        end
      endcase
    end
  end

  // The lane enable wraps back to bit0 on the same edge the group moves on.
  assign lane_wrap  = ENX_Int[GRP_SIZE-1];
  assign lane_load  = start | to_idle | (advance & lane_wrap);
  assign lane_shift = advance & ~lane_wrap;
  assign grp_load   = start | to_idle;
  assign grp_shift  = advance & lane_wrap;

  onehot_shift #(
    .WIDTH (GRP_SIZE)
  ) u_lane_en (
    .clk      (clk),
    .rst_n    (GlobalReset_n),
    .load_i   (lane_load),
    .shift_i  (lane_shift),
    .onehot_o (ENX_Int)
  );

  onehot_shift #(
    .WIDTH (N_GRP)
  ) u_grp_en (
    .clk      (clk),
    .rst_n    (GlobalReset_n),
    .load_i   (grp_load),
    .shift_i  (grp_shift),
    .onehot_o (ENX_Int_2)
  );

  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      drain_q   <= '0;
      enx_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      drain_q   <= drain_d;
      enx_q     <= (state_d == FIRE);
      valid_q   <= (state_d == VALID);
      busy_q    <= (state_d != IDLE);
      overrun_q <= overrun_d;
    end
  end

  assign WeightX_Select = tap_q;
  assign PixelX_Select  = tap_q;
  assign ENX            = enx_q;
  assign Output_Valid   = valid_q;
  assign Busy           = busy_q;
  assign Overrun        = overrun_q;

endmodule
